// File: rtl/en_reset_pipe_pkg.sv
// en_reset_pipe_pkg: shared helpers for the elastic reset pipeline
package en_reset_pipe_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) r = ((1 << i) < v) ? i + 1 : r;
    return r;
  endfunction

endpackage

// File: rtl/en_reset_pipe_if.sv
// en_reset_pipe_if: valid/ready input and output channels plus flush and occupancy
interface en_reset_pipe_if import en_reset_pipe_pkg::*; #(
  parameter int p_nbits   = 1,
  parameter int p_nstages = 2
) ();
  logic                                in_val;
  logic                                in_rdy;
  logic [p_nbits-1:0]                  in_msg;
  logic                                out_val;
  logic                                out_rdy;
  logic [p_nbits-1:0]                  out_msg;
  logic                                flush;
  logic [clog2(p_nstages + 1)-1:0]     count;

  modport master (output in_val, in_msg, out_rdy, flush, input in_rdy, out_val, out_msg, count);
  modport slave  (input in_val, in_msg, out_rdy, flush, output in_rdy, out_val, out_msg, count);
endinterface

// File: rtl/en_reset_pipe_stage.sv
// en_reset_pipe_stage: one pipeline slot, a valid bit plus a data word loaded on enable
module en_reset_pipe_stage #(
  parameter int                 p_nbits       = 1,
  parameter logic [p_nbits-1:0] p_reset_value = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_en,
  input  logic               i_val,
  input  logic [p_nbits-1:0] i_data,
  output logic               o_val,
  output logic [p_nbits-1:0] o_data
);
  logic               r_val;
  logic [p_nbits-1:0] r_data;

  // valid follows upstream on enable; data only captured for a valid upstream word
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_val  <= 1'b0;
      r_data <= p_reset_value;
    end else if (i_en) begin
      r_val <= i_val;
      if (i_val) r_data <= i_data;
    end

  assign o_val  = r_val;
  assign o_data = r_data;
endmodule

// File: rtl/en_reset_pipe.sv
// en_reset_pipe: full-throughput elastic pipeline with flush, async reset and occupancy count
module en_reset_pipe import en_reset_pipe_pkg::*; #(
  parameter int                 p_nbits       = 1,
  parameter int                 p_nstages     = 2,
  parameter logic [p_nbits-1:0] p_reset_value = '0,
  parameter int                 p_id          = 0
) (
  input logic           clk,
  input logic           reset,
  en_reset_pipe_if.slave bus
);
  localparam int lp_cw = clog2(p_nstages + 1);

  // index 0 is the input port, index k+1 is the output of stage k
  logic [p_nstages:0] w_val;
  logic [p_nbits-1:0] w_data [p_nstages+1];
  logic [p_nstages:0] w_rdy;
  logic               w_in_xfer;
  logic               w_out_xfer;
  logic [lp_cw-1:0]   r_count;

  assign w_val[0]  = bus.in_val;
  assign w_data[0] = bus.in_msg;

  // ready ripples back from the output: a slot can take data if empty or draining
  always_comb begin
    w_rdy[p_nstages] = bus.out_rdy;
    for (int i = p_nstages - 1; i >= 0; i--) w_rdy[i] = !w_val[i+1] || w_rdy[i+1];
  end

  for (genvar g = 0; g < p_nstages; g++) begin : g_stage
    en_reset_pipe_stage #(.p_nbits(p_nbits), .p_reset_value(p_reset_value)) u_stage (
      .clk    (clk),
      .reset  (reset),
      .i_en   (w_rdy[g] || bus.flush),
      .i_val  (w_val[g] && !bus.flush),
      .i_data (w_data[g]),
      .o_val  (w_val[g+1]),
      .o_data (w_data[g+1])
    );
  end

  assign bus.in_rdy  = w_rdy[0] && !bus.flush && !reset;
  assign bus.out_val = w_val[p_nstages] && !bus.flush && !reset;
  assign bus.out_msg = w_data[p_nstages];
  assign bus.count   = r_count;
  assign w_in_xfer   = bus.in_val && bus.in_rdy;
  assign w_out_xfer  = bus.out_val && bus.out_rdy;

  // occupancy tracks transfers in minus transfers out; flush empties the pipe
  always_ff @(posedge clk or posedge reset)
    if (reset) r_count <= '0;
    else if (bus.flush) r_count <= '0;
    else if (w_in_xfer && !w_out_xfer) r_count <= r_count + 1'b1;
    else if (w_out_xfer && !w_in_xfer) r_count <= r_count - 1'b1;

  x_inputs: assert property (@(posedge clk) disable iff (reset) !$isunknown({bus.in_val, bus.out_rdy, bus.flush}))
    else $error("en_reset_pipe[%0d]: unknown value on in_val/out_rdy/flush", p_id);
endmodule

// File: tb/tb_en_reset_pipe.sv
// tb_en_reset_pipe: randomized and directed checks against a queue-based latency model
module tb_en_reset_pipe;
  logic       clk   = 1'b0;
  logic       rst_a = 1'b1;
  logic       rst_b = 1'b1;
  int         ec    = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] qm0[$];
  logic [7:0] qm1[$];
  int         qt0[$];
  int         qt1[$];
  logic       gv, gr;
  logic [7:0] gm;
  int         gc;

  always #5 clk = ~clk;
  always @(posedge clk) ec <= ec + 1;

  en_reset_pipe_if #(.p_nbits(8), .p_nstages(3)) ifa ();
  en_reset_pipe_if #(.p_nbits(8), .p_nstages(1)) ifb ();

  en_reset_pipe #(.p_nbits(8), .p_nstages(3), .p_reset_value(8'hA5), .p_id(1)) dut_a (
    .clk(clk), .reset(rst_a), .bus(ifa.slave));
  en_reset_pipe #(.p_nbits(8), .p_nstages(1), .p_reset_value(8'h00), .p_id(2)) dut_b (
    .clk(clk), .reset(rst_b), .bus(ifb.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int d, input bit v, input logic [7:0] m, input bit o, input bit f);
    if (d == 0) begin
      ifa.in_val = v; ifa.in_msg = m; ifa.out_rdy = o; ifa.flush = f;
    end else begin
      ifb.in_val = v; ifb.in_msg = m; ifb.out_rdy = o; ifb.flush = f;
    end
  endtask

  task automatic sample(input int d, output logic v, output logic r, output logic [7:0] m, output int c);
    v = d == 0 ? ifa.out_val : ifb.out_val;
    r = d == 0 ? ifa.in_rdy : ifb.in_rdy;
    m = d == 0 ? ifa.out_msg : ifb.out_msg;
    c = d == 0 ? int'(ifa.count) : int'(ifb.count);
  endtask

  // one cycle: drive at negedge, compare against the model, let the edge pass, update the model
  task automatic step(input int d, input bit v, input logic [7:0] m, input bit o, input bit f,
                      output logic ov, output logic orr, output logic [7:0] om, output int oc);
    int n, sz, ht, e0;
    logic [7:0] hm;
    bit ev, er;
    string p;
    p = d == 0 ? "a_" : "b_";
    n = d == 0 ? 3 : 1;
    drive(d, v, m, o, f);
    #1;
    sample(d, ov, orr, om, oc);
    sz = d == 0 ? qm0.size() : qm1.size();
    hm = 8'h00;
    ht = 0;
    if (sz > 0) begin
      hm = d == 0 ? qm0[0] : qm1[0];
      ht = d == 0 ? qt0[0] : qt1[0];
    end
    er = !f && !(sz == n && !o);
    ev = !f && sz > 0 && ec >= ht + n;
    chk({p, "in_rdy"}, orr, er);
    chk({p, "out_val"}, ov, ev);
    if (ev) chk({p, "out_msg"}, om, hm);
    chk({p, "count"}, oc, sz);
    e0 = ec;
    @(posedge clk);
    #1;
    if (d == 0) begin
      if (f) begin qm0.delete(); qt0.delete(); end
      else begin
        if (ev && o) begin void'(qm0.pop_front()); void'(qt0.pop_front()); end
        if (v && er) begin qm0.push_back(m); qt0.push_back(e0); end
      end
    end else begin
      if (f) begin qm1.delete(); qt1.delete(); end
      else begin
        if (ev && o) begin void'(qm1.pop_front()); void'(qt1.pop_front()); end
        if (v && er) begin qm1.push_back(m); qt1.push_back(e0); end
      end
    end
    @(negedge clk);
  endtask

  // assert reset between edges while inputs try to transfer, then release at a negedge
  task automatic do_reset(input int d);
    logic v, r;
    logic [7:0] m;
    int c;
    string p;
    p = d == 0 ? "a_" : "b_";
    drive(d, 1'b1, 8'h3C, 1'b1, 1'b0);
    #2;
    if (d == 0) rst_a = 1'b1; else rst_b = 1'b1;
    #1;
    sample(d, v, r, m, c);
    chk({p, "rst_out_val"}, v, 0);
    chk({p, "rst_in_rdy"}, r, 0);
    chk({p, "rst_count"}, c, 0);
    chk({p, "rst_out_msg"}, m, d == 0 ? 8'hA5 : 8'h00);
    if (d == 0) begin qm0.delete(); qt0.delete(); end
    else begin qm1.delete(); qt1.delete(); end
    @(posedge clk);
    #1;
    sample(d, v, r, m, c);
    chk({p, "rst_hold_count"}, c, 0);
    chk({p, "rst_hold_val"}, v, 0);
    @(negedge clk);
    if (d == 0) rst_a = 1'b0; else rst_b = 1'b0;
  endtask

  initial begin
    drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    sample(0, gv, gr, gm, gc);
    chk("init_a_val", gv, 0);
    chk("init_a_rdy", gr, 0);
    chk("init_a_msg", gm, 8'hA5);
    chk("init_a_count", gc, 0);
    sample(1, gv, gr, gm, gc);
    chk("init_b_val", gv, 0);
    chk("init_b_msg", gm, 8'h00);
    rst_a = 1'b0;
    rst_b = 1'b0;

    for (int j = 0; j < 8; j++) begin
      step(0, j < 5, 8'(j + 1), 1'b1, 1'b0, gv, gr, gm, gc);
      if (j >= 3) begin
        chk("stream_val", gv, 1);
        chk("stream_msg", gm, 32'(j - 2));
      end
    end

    for (int j = 0; j < 4; j++) begin
      step(0, 1'b1, 8'(8'h10 + j), 1'b0, 1'b0, gv, gr, gm, gc);
      if (j == 3) begin
        chk("bp_full_rdy", gr, 0);
        chk("bp_full_count", gc, 3);
      end
    end
    for (int j = 0; j < 4; j++) begin
      step(0, 1'b1, 8'(8'h13 + j), 1'b1, 1'b0, gv, gr, gm, gc);
      chk("bp_msg", gm, 32'(8'h10 + j));
      chk("bp_rdy", gr, 1);
      chk("bp_count", gc, 3);
    end
    repeat (4) step(0, 1'b0, 8'h00, 1'b1, 1'b0, gv, gr, gm, gc);

    step(0, 1'b1, 8'h31, 1'b0, 1'b0, gv, gr, gm, gc);
    step(0, 1'b1, 8'h32, 1'b0, 1'b0, gv, gr, gm, gc);
    step(0, 1'b0, 8'h00, 1'b0, 1'b0, gv, gr, gm, gc);
    step(0, 1'b1, 8'h33, 1'b1, 1'b1, gv, gr, gm, gc);
    chk("flush_val", gv, 0);
    chk("flush_rdy", gr, 0);
    step(0, 1'b0, 8'h00, 1'b1, 1'b0, gv, gr, gm, gc);
    chk("flush_count", gc, 0);
    chk("flush_after_val", gv, 0);
    repeat (3) step(0, 1'b0, 8'h00, 1'b1, 1'b0, gv, gr, gm, gc);

    step(0, 1'b1, 8'h41, 1'b1, 1'b0, gv, gr, gm, gc);
    step(0, 1'b1, 8'h42, 1'b1, 1'b0, gv, gr, gm, gc);
    do_reset(0);
    step(0, 1'b1, 8'h5A, 1'b1, 1'b0, gv, gr, gm, gc);
    chk("rst_fresh_rdy", gr, 1);
    repeat (3) step(0, 1'b0, 8'h00, 1'b1, 1'b0, gv, gr, gm, gc);
    chk("rst_fresh_msg", gm, 8'h5A);

    drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int j = 0; j < 6; j++) begin
      step(1, 1'b1, 8'(8'h60 + j), 1'b1, 1'b0, gv, gr, gm, gc);
      if (j >= 1) begin
        chk("n1_val", gv, 1);
        chk("n1_msg", gm, 32'(8'h60 + j - 1));
        chk("n1_rdy", gr, 1);
      end
    end
    step(1, 1'b0, 8'h00, 1'b1, 1'b0, gv, gr, gm, gc);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 250; i++) begin
        if ($urandom_range(0, 49) == 0) do_reset(d);
        else step(d, $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 15) == 0, gv, gr, gm, gc);
      end
      drive(d, 1'b0, 8'h00, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
